// File: rtl/pipeline_hazard_ctrl_if.sv
// Decode-side hazard bus: decode/branch/memory status in, forwarding and stall controls out.
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned REG_ADDRESS_LENGTH = 5
);
  logic                          id_valid;
  logic [REG_ADDRESS_LENGTH-1:0] id_ra;
  logic [REG_ADDRESS_LENGTH-1:0] id_rb;
  logic                          id_ra_used;
  logic                          id_rb_used;
  logic [REG_ADDRESS_LENGTH-1:0] id_rd;
  logic                          id_write_en;
  logic                          id_is_load;
  logic                          branch_taken;
  logic                          mem_busy;
  logic [2:0]                    fwd_sel_a;
  logic [2:0]                    fwd_sel_b;
  logic                          stall_if;
  logic                          bubble_ex;
  logic                          freeze;
  logic                          flush_ifid;
  logic [31:0]                   stall_cycles;

  modport master (
    output id_valid, id_ra, id_rb, id_ra_used, id_rb_used, id_rd,
           id_write_en, id_is_load, branch_taken, mem_busy,
    input  fwd_sel_a, fwd_sel_b, stall_if, bubble_ex, freeze,
           flush_ifid, stall_cycles
  );

  modport slave (
    input  id_valid, id_ra, id_rb, id_ra_used, id_rb_used, id_rd,
           id_write_en, id_is_load, branch_taken, mem_busy,
    output fwd_sel_a, fwd_sel_b, stall_if, bubble_ex, freeze,
           flush_ifid, stall_cycles
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Scoreboard-based forwarding, load-use interlock, memory freeze and branch
// flush qualification for an in-order pipeline.
module pipeline_hazard_ctrl #(
  parameter int unsigned REG_ADDRESS_LENGTH = 5,
  parameter int unsigned NUM_STAGES         = 2,
  parameter int unsigned LOAD_STAGE         = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  pipeline_hazard_ctrl_if.slave  hz
);

  typedef struct packed {
    logic                          v;
    logic [REG_ADDRESS_LENGTH-1:0] rd;
    logic                          we;
    logic                          ld;
  } entry_t;

  entry_t      sb_q [1:NUM_STAGES];
  entry_t      sb_d [1:NUM_STAGES];
  logic [31:0] stall_cycles_q, stall_cycles_d;

  entry_t     new_entry;
  logic [2:0] sel_a, sel_b;
  logic       match_a, match_b, hazard, stall;

  // Scan oldest to youngest so the youngest match overwrites the select.
  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    hazard  = 1'b0;
    match_a = 1'b0;
    match_b = 1'b0;
    for (int unsigned k = NUM_STAGES; k >= 1; k--) begin
      match_a = sb_q[k].v & sb_q[k].we & (sb_q[k].rd == hz.id_ra) & hz.id_ra_used;
      match_b = sb_q[k].v & sb_q[k].we & (sb_q[k].rd == hz.id_rb) & hz.id_rb_used;
      if (match_a) sel_a = 3'(k);
      if (match_b) sel_b = 3'(k);
      if ((match_a || match_b) && sb_q[k].ld && (k < LOAD_STAGE)) hazard = 1'b1;
    end
    hazard = hazard & hz.id_valid;
  end

  assign stall = hz.mem_busy | hazard;

  assign hz.fwd_sel_a    = rst ? '0 : sel_a;
  assign hz.fwd_sel_b    = rst ? '0 : sel_b;
  assign hz.freeze       = ~rst & hz.mem_busy;
  assign hz.stall_if     = ~rst & stall;
  assign hz.bubble_ex    = ~rst & ~hz.mem_busy & hazard;
  assign hz.flush_ifid   = ~rst & ~hz.mem_busy & ~hazard & hz.id_valid & hz.branch_taken;
  assign hz.stall_cycles = stall_cycles_q;

  always_comb begin
    new_entry.v  = hz.id_valid;
    new_entry.rd = hz.id_rd;
    new_entry.we = hz.id_write_en & hz.id_valid;
    new_entry.ld = hz.id_is_load;
  end

  // Freeze holds everything; a hazard shifts the pipe but injects an empty entry.
  always_comb begin
    sb_d           = sb_q;
    stall_cycles_d = stall_cycles_q;
    if (!hz.mem_busy) begin
      for (int unsigned k = NUM_STAGES; k >= 2; k--) begin
        sb_d[k] = sb_q[k-1];
      end
      sb_d[1] = hazard ? '0 : new_entry;
    end
    if (stall && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 1; k <= NUM_STAGES; k++) begin
        sb_q[k] <= '0;
      end
      stall_cycles_q <= '0;
    end else begin
      sb_q           <= sb_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench: a cycle-by-cycle vector table on the default configuration,
// plus hand sequences for reset during a stall and LOAD_STAGE=1.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.REG_ADDRESS_LENGTH(5)) bus ();
  pipeline_hazard_ctrl_if #(.REG_ADDRESS_LENGTH(5)) bus1 ();

  pipeline_hazard_ctrl #(.REG_ADDRESS_LENGTH(5), .NUM_STAGES(2), .LOAD_STAGE(2)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (bus.slave)
  );

  pipeline_hazard_ctrl #(.REG_ADDRESS_LENGTH(5), .NUM_STAGES(2), .LOAD_STAGE(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .hz  (bus1.slave)
  );

  typedef struct {
    logic       valid;
    logic [4:0] ra, rb;
    logic       rau, rbu;
    logic [4:0] rd;
    logic       we, ld, br, busy;
    logic [2:0] fa, fb;
    logic       st, bu, fz, fl;
    int         sc;
  } vec_t;

  vec_t vecs [24];
  int   tests = 0;
  int   fails = 0;

  function automatic vec_t mk(input logic valid, input int ra, input int rb,
                              input logic rau, input logic rbu, input int rd,
                              input logic we, input logic ld, input logic br,
                              input logic busy, input int fa, input int fb,
                              input logic st, input logic bu, input logic fz,
                              input logic fl, input int sc);
    vec_t r;
    r.valid = valid; r.ra = 5'(ra); r.rb = 5'(rb); r.rau = rau; r.rbu = rbu;
    r.rd = 5'(rd); r.we = we; r.ld = ld; r.br = br; r.busy = busy;
    r.fa = 3'(fa); r.fb = 3'(fb); r.st = st; r.bu = bu; r.fz = fz; r.fl = fl;
    r.sc = sc;
    return r;
  endfunction

  task automatic chk(input string name, input int step, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, step, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.id_valid = v.valid; bus.id_ra = v.ra; bus.id_rb = v.rb;
    bus.id_ra_used = v.rau; bus.id_rb_used = v.rbu; bus.id_rd = v.rd;
    bus.id_write_en = v.we; bus.id_is_load = v.ld;
    bus.branch_taken = v.br; bus.mem_busy = v.busy;
  endtask

  task automatic drive1(input vec_t v);
    bus1.id_valid = v.valid; bus1.id_ra = v.ra; bus1.id_rb = v.rb;
    bus1.id_ra_used = v.rau; bus1.id_rb_used = v.rbu; bus1.id_rd = v.rd;
    bus1.id_write_en = v.we; bus1.id_is_load = v.ld;
    bus1.branch_taken = v.br; bus1.mem_busy = v.busy;
  endtask

  task automatic check_all(input int step, input vec_t v);
    chk("fwd_sel_a",    step, 32'(bus.fwd_sel_a),  32'(v.fa));
    chk("fwd_sel_b",    step, 32'(bus.fwd_sel_b),  32'(v.fb));
    chk("stall_if",     step, 32'(bus.stall_if),   32'(v.st));
    chk("bubble_ex",    step, 32'(bus.bubble_ex),  32'(v.bu));
    chk("freeze",       step, 32'(bus.freeze),     32'(v.fz));
    chk("flush_ifid",   step, 32'(bus.flush_ifid), 32'(v.fl));
    chk("stall_cycles", step, bus.stall_cycles,    32'(v.sc));
  endtask

  vec_t idle;

  initial begin
    idle = mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0);
    //            vld ra rb au bu rd we ld br busy | fa fb st bu fz fl sc
    vecs[0]  = mk(0,  0, 0, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(1,  1, 2, 1, 1, 3, 1, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0);
    vecs[2]  = mk(1,  3, 1, 1, 1, 6, 1, 0, 0, 0,    1, 0, 0, 0, 0, 0, 0);
    vecs[3]  = mk(1,  1, 2, 1, 1, 3, 1, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0);
    vecs[4]  = mk(0,  0, 0, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0);
    vecs[5]  = mk(1,  7, 3, 1, 1, 8, 1, 0, 0, 0,    0, 2, 0, 0, 0, 0, 0);
    vecs[6]  = mk(1,  7, 3, 1, 1, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0);
    vecs[7]  = mk(1,  1, 2, 1, 1, 5, 1, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0);
    vecs[8]  = mk(1,  5, 2, 1, 1, 5, 1, 0, 0, 0,    1, 0, 0, 0, 0, 0, 0);
    vecs[9]  = mk(1,  5, 5, 1, 1, 9, 1, 0, 0, 0,    1, 1, 0, 0, 0, 0, 0);
    vecs[10] = mk(1,  1, 0, 1, 0, 4, 1, 1, 0, 0,    0, 0, 0, 0, 0, 0, 0);
    vecs[11] = mk(1,  4, 9, 1, 1,10, 1, 0, 0, 0,    1, 2, 1, 1, 0, 0, 0);
    vecs[12] = mk(1,  4, 9, 1, 1,10, 1, 0, 0, 0,    2, 0, 0, 0, 0, 0, 1);
    vecs[13] = mk(1, 10, 1, 1, 1,11, 1, 0, 1, 1,    1, 0, 1, 0, 1, 0, 1);
    vecs[14] = mk(1, 10, 1, 1, 1,11, 1, 0, 1, 1,    1, 0, 1, 0, 1, 0, 2);
    vecs[15] = mk(1, 10, 1, 1, 1,11, 1, 0, 1, 1,    1, 0, 1, 0, 1, 0, 3);
    vecs[16] = mk(1, 10, 1, 1, 1,11, 1, 0, 1, 0,    1, 0, 0, 0, 0, 1, 4);
    vecs[17] = mk(1,  0, 0, 1, 0,12, 1, 1, 0, 0,    0, 0, 0, 0, 0, 0, 4);
    vecs[18] = mk(1, 12, 0, 1, 0,13, 1, 0, 1, 1,    1, 0, 1, 0, 1, 0, 4);
    vecs[19] = mk(1, 12, 0, 1, 0,13, 1, 0, 1, 0,    1, 0, 1, 1, 0, 0, 5);
    vecs[20] = mk(1, 12, 0, 1, 0,13, 1, 0, 1, 0,    2, 0, 0, 0, 0, 1, 6);
    vecs[21] = mk(1, 13, 0, 1, 0, 0, 1, 0, 0, 0,    1, 0, 0, 0, 0, 0, 6);
    vecs[22] = mk(1,  0,13, 1, 1,14, 1, 0, 0, 0,    1, 2, 0, 0, 0, 0, 6);
    vecs[23] = mk(1, 14, 0, 0, 1, 0, 0, 0, 0, 0,    0, 2, 0, 0, 0, 0, 6);

    drive(idle);
    drive1(idle);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 24; i++) begin
      if (i != 0) begin
        @(posedge clk);
        #1;
      end
      drive(vecs[i]);
      #3;
      check_all(i, vecs[i]);
    end

    // Reset arriving while a load-use stall is active.
    @(posedge clk); #1;
    drive(mk(1, 1, 0, 1, 0, 4, 1, 1, 0, 0, 0,0,0,0,0,0,0));
    @(posedge clk); #1;
    drive(mk(1, 4, 0, 1, 0, 10, 1, 0, 0, 0, 0,0,0,0,0,0,0));
    #3;
    chk("rst_pre_stall", 100, 32'(bus.stall_if), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #3;
    check_all(101, mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0));

    // LOAD_STAGE=1: a back-to-back load-use pair forwards from stage 1 with no stall.
    @(posedge clk); #1;
    drive(idle);
    drive1(mk(1, 1, 0, 1, 0, 4, 1, 1, 0, 0, 0,0,0,0,0,0,0));
    @(posedge clk); #1;
    drive1(mk(1, 4, 0, 1, 0, 10, 1, 0, 0, 0, 0,0,0,0,0,0,0));
    #3;
    chk("ls1_fwd_sel_a",    200, 32'(bus1.fwd_sel_a), 32'd1);
    chk("ls1_stall_if",     200, 32'(bus1.stall_if),  32'd0);
    chk("ls1_bubble_ex",    200, 32'(bus1.bubble_ex), 32'd0);
    chk("ls1_stall_cycles", 200, bus1.stall_cycles,   32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Parametrised hazard, forwarding and stall controller for the next-generation in-order integer pipeline. It sits beside the decode stage and tracks the destination of every in-flight instruction in a `NUM_STAGES`-deep scoreboard shift register. It drives the operand forwarding selects, load-use interlock, data-memory freeze and branch flush qualification. It replaces the single-stage compare-only HDU with a depth-, load-latency- and back-pressure-aware unit.

## Interface
Parameters:
- `REG_ADDRESS_LENGTH`, default 5: register address width.
- `NUM_STAGES`, default 2: tracked stages after decode, legal 1..4. Stage 1 is the ID/EX register; stage `NUM_STAGES` is written back at the end of its cycle.
- `LOAD_STAGE`, default 2: first stage index at which a load result is forwardable, legal 1..`NUM_STAGES`. Setting it to 1 disables load-use stalls.

Ports (clock and reset: one clock; reset is synchronous and active-high):
- `clk` input 1: clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `id_valid` input 1: decode holds a valid instruction.
- `id_ra`, `id_rb` input `REG_ADDRESS_LENGTH`: source addresses.
- `id_ra_used`, `id_rb_used` input 1: source is actually read.
- `id_rd` input `REG_ADDRESS_LENGTH`: destination address.
- `id_write_en` input 1: instruction writes `id_rd`.
- `id_is_load` input 1: instruction is a load.
- `branch_taken` input 1: raw taken from the branch unit.
- `mem_busy` input 1: data memory not ready; whole pipeline must hold.
- `fwd_sel_a`, `fwd_sel_b` output 3: 0 = register file, k = stage-k result.
- `stall_if` output 1: hold PC and the IF/ID register.
- `bubble_ex` output 1: load a NOP into ID/EX.
- `freeze` output 1: all stage registers hold.
- `flush_ifid` output 1: qualified branch; PC loads target and IF/ID is cleared.
- `stall_cycles` output 32: saturating count of cycles with `stall_if`=1.

## Operation
- **Scoreboard entry per stage k:** {v, rd, we, ld}.
  - A match for source s at stage k requires v & we & rd==s & the source's used flag.
  - Register 0 has no special treatment.
- **Forward select:** the lowest k with a match (youngest wins). The select is 0 if there is no match.
- **Hazard:** `hazard` = `id_valid` & (a matching entry has ld=1 and k < `LOAD_STAGE`), evaluated for either source.
- **Priority per cycle:** `rst` > `mem_busy` > `hazard` > normal.
- **Freeze** (`mem_busy`=1):
  - Outputs: `freeze`=1, `stall_if`=1, `bubble_ex`=0, `flush_ifid`=0.
  - The scoreboard holds.
  - The branch source must hold `branch_taken` until it is unfrozen.
- **Hazard:**
  - Outputs: `stall_if`=1, `bubble_ex`=1, `flush_ifid`=0.
  - Scoreboard: entry k+1 ← entry k, and entry 1 ← invalid.
- **Normal:**
  - Scoreboard: entry k+1 ← entry k, and entry 1 ← {`id_valid`, `id_rd`, `id_write_en`&`id_valid`, `id_is_load`}.
  - `flush_ifid` = `id_valid` & `branch_taken`.
- Entry `NUM_STAGES` is dropped on shift; its write is committed to the register file at that edge.
- `stall_cycles` increments on every cycle with `stall_if`=1 (freeze or hazard) and saturates at 0xFFFF_FFFF.

## Timing
- All outputs except `stall_cycles` are combinational from the current scoreboard plus ID inputs, valid in the same cycle.
- The scoreboard and `stall_cycles` update at the rising edge.
- Load-use stall length is `LOAD_STAGE`−k cycles for a match at stage k.
  - Example: with `LOAD_STAGE`=2 and a back-to-back load-use pair, the stall is 1 cycle.
- After the stall, the consumer sees `fwd_sel` = `LOAD_STAGE`.
- **Reset:** all entries invalid and `stall_cycles`=0. Consequently, in the cycle after `rst`, all outputs are 0, including when reset lands mid-stall or mid-freeze.
- Simultaneous `mem_busy` and `hazard`: freeze wins, no bubble; the hazard is re-evaluated after the freeze ends.
- `branch_taken` coincident with `hazard` is suppressed. The branch operand may be stale, so the branch is re-evaluated after the stall.

## Test plan
Defaults for all scenarios: `NUM_STAGES`=2, `LOAD_STAGE`=2.
- **Back-to-back ALU:** ADD r3 then SUB using r3 as A → `fwd_sel_a`=1, `stall_if`=0.
- **Distance-two forward:** ADD r3, NOP, then use of r3 as B → `fwd_sel_b`=2. One cycle later, with r3 retired → `fwd_sel_b`=0.
- **Youngest wins:** ADD r5 then OR r5, then use of r5 → `fwd_sel_a`=1, not 2.
- **Load-use:** LOAD r4 then ADD using r4 → cycle 1: `stall_if`=1, `bubble_ex`=1. Cycle 2: `fwd_sel_a`=2, `stall_if`=0. `stall_cycles`=1. Repeat with `LOAD_STAGE`=1 → no stall and `fwd_sel_a`=1.
- **Freeze:** `mem_busy`=1 for 3 cycles with `branch_taken`=1 → `freeze`=1, `stall_if`=1, `bubble_ex`=0, `flush_ifid`=0. Forward selects are unchanged across the 3 cycles. `stall_cycles` rises by 3. `flush_ifid`=1 on the first unfrozen cycle.
- **Reset mid-operation:** assert `rst` during a load-use stall → next cycle all outputs are 0, `stall_cycles`=0, and the former consumer gets `fwd_sel`=0.
